// File: rtl/seq_ser_pkg.sv
// Shared constants for the pattern serializer: FSM encodings, default
// geometry and a constant clog2 used to size the counter and bit index.
package seq_ser_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int DEF_WIDTH      = 12;
  localparam int DEF_CLR_CYCLES = 2;
  localparam int DEF_GAP_CYCLES = 1;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_pattern_serializer_if.sv
// Pattern handshake and serial-output bundle for seq_pattern_serializer.
// Optional macro SER_REPEAT_EN adds the rep_cnt repetition request.
interface seq_pattern_serializer_if
  import seq_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDX_W = clog2(WIDTH);

  logic [WIDTH-1:0] pat_data;
  logic             pat_valid;
  logic             pat_ready;
  logic             clr_req;
`ifdef SER_REPEAT_EN
  logic [3:0]       rep_cnt;
`endif
  logic             det_clr;
  logic             seq_out;
  logic             seq_valid;
  logic             busy;
  logic             frame_done;
  logic [IDX_W-1:0] bit_idx;

  // Upstream side: supplies patterns, watches the serial stream
  modport master (
`ifdef SER_REPEAT_EN
    output rep_cnt,
`endif
    output pat_data, pat_valid, clr_req,
    input  pat_ready, det_clr, seq_out, seq_valid, busy, frame_done, bit_idx
  );

  // Serializer side
  modport slave (
`ifdef SER_REPEAT_EN
    input  rep_cnt,
`endif
    input  pat_data, pat_valid, clr_req,
    output pat_ready, det_clr, seq_out, seq_valid, busy, frame_done, bit_idx
  );

endinterface

// File: rtl/seq_ser_cnt.sv
// Loadable down-counter timing the CLEAR, SHIFT and GAP phases.
// Load wins over decrement; the count holds at zero instead of wrapping.
module seq_ser_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Reload on phase entry, otherwise step toward zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/seq_pattern_serializer.sv
// Serializes a WIDTH-bit pattern LSB first toward a sequence detector,
// with an optional leading detector clear and a trailing idle gap.
// Optional macro SER_REPEAT_EN: resend the pattern rep_cnt+1 times.
module seq_pattern_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  seq_pattern_serializer_if.slave bus
);

  localparam int IDX_W   = clog2(WIDTH);
  localparam int MAX_LEN = (WIDTH > CLR_CYCLES) ?
                           ((WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES) :
                           ((CLR_CYCLES > GAP_CYCLES) ? CLR_CYCLES : GAP_CYCLES);
  localparam int CNT_W   = clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic             det_clr_reg, det_clr_next;
  logic             seq_out_reg, seq_out_next;
  logic             seq_valid_reg, seq_valid_next;
  logic             frame_done_reg, frame_done_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic             xfer, frame_end, rep_more;
  logic [WIDTH-1:0] reload_pat;

  seq_ser_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign xfer      = (state_reg == ST_IDLE) && bus.pat_valid;
  // A repetition is over once its gap (or, with no gap, its last bit) ends
  assign frame_end = ((state_reg == ST_SHIFT) && cnt_zero && (GAP_CYCLES == 0)) ||
                     ((state_reg == ST_GAP) && cnt_zero);

`ifdef SER_REPEAT_EN
  logic [WIDTH-1:0] pat_hold_reg;
  logic [3:0]       rep_left_reg;

  // Keep a copy of the pattern and count the repetitions still owed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_hold_reg <= '0;
      rep_left_reg <= '0;
    end else if (xfer) begin
      pat_hold_reg <= bus.pat_data;
      rep_left_reg <= bus.rep_cnt;
    end else if (frame_end && (rep_left_reg != 4'd0)) begin
      rep_left_reg <= rep_left_reg - 4'd1;
    end
  end

  assign rep_more   = (rep_left_reg != 4'd0);
  assign reload_pat = pat_hold_reg;
`else
  assign rep_more   = 1'b0;
  assign reload_pat = shreg_reg;
`endif

  // Phase sequencing; outputs are computed one cycle ahead and registered
  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    det_clr_next    = 1'b0;
    seq_out_next    = 1'b0;
    seq_valid_next  = 1'b0;
    frame_done_next = 1'b0;
    bit_idx_next    = '0;
    cnt_load        = 1'b0;
    cnt_load_val    = SHIFT_LOAD;
    cnt_dec         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (xfer) begin
          shreg_next = bus.pat_data;
          cnt_load   = 1'b1;
          if (bus.clr_req) begin
            state_next   = ST_CLEAR;
            cnt_load_val = CLR_LOAD;
            det_clr_next = 1'b1;
          end else begin
            state_next     = ST_SHIFT;
            seq_out_next   = bus.pat_data[0];
            seq_valid_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (cnt_zero) begin
          state_next     = ST_SHIFT;
          cnt_load       = 1'b1;
          seq_out_next   = shreg_reg[0];
          seq_valid_next = 1'b1;
        end else begin
          cnt_dec      = 1'b1;
          det_clr_next = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
          // Last bit just went out: the detector's answer is visible next cycle
          frame_done_next = 1'b1;
          state_next      = ST_GAP;
          cnt_load        = 1'b1;
          cnt_load_val    = GAP_LOAD;
        end else begin
          cnt_dec        = 1'b1;
          shreg_next     = shreg_reg >> 1;
          seq_out_next   = shreg_reg[1];
          seq_valid_next = 1'b1;
          bit_idx_next   = bit_idx_reg + IDX_W'(1);
        end
      end
      default: begin
        if (!cnt_zero) cnt_dec = 1'b1;
      end
    endcase
    // End of a repetition: either start the next one or return to IDLE
    if (frame_end) begin
      if (rep_more) begin
        state_next     = ST_SHIFT;
        cnt_load       = 1'b1;
        cnt_load_val   = SHIFT_LOAD;
        shreg_next     = reload_pat;
        seq_out_next   = reload_pat[0];
        seq_valid_next = 1'b1;
        bit_idx_next   = '0;
      end else begin
        state_next = ST_IDLE;
        cnt_load   = 1'b0;
      end
    end
  end

  // State and registered outputs; reset aborts any frame immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      shreg_reg      <= '0;
      det_clr_reg    <= 1'b0;
      seq_out_reg    <= 1'b0;
      seq_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      bit_idx_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      det_clr_reg    <= det_clr_next;
      seq_out_reg    <= seq_out_next;
      seq_valid_reg  <= seq_valid_next;
      frame_done_reg <= frame_done_next;
      bit_idx_reg    <= bit_idx_next;
    end
  end

  assign bus.pat_ready  = (state_reg == ST_IDLE);
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.det_clr    = det_clr_reg;
  assign bus.seq_out    = seq_out_reg;
  assign bus.seq_valid  = seq_valid_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.bit_idx    = bit_idx_reg;

endmodule

// File: tb/tb_seq_pattern_serializer.sv
// Self-checking bench for seq_pattern_serializer: a table of directed frames,
// hand-written reset/handshake sequences and randomized frames checked
// cycle by cycle against a timeline model derived from the latency rules.
// Build with SER_REPEAT_EN defined to also exercise repeated frames.
module tb_seq_pattern_serializer;
  import seq_ser_pkg::*;

  localparam int W     = 12;
  localparam int CLR   = 2;
  localparam int GAP   = 1;
  localparam int IDX_W = clog2(W);
  localparam int P     = W + GAP;

  typedef logic [6+IDX_W-1:0] obs_t;  // {rdy,busy,clr,vld,out,done,idx}
  localparam obs_t RST_OBS = {1'b1, 5'b0, {IDX_W{1'b0}}};

  typedef struct {
    logic [W-1:0] pat;
    bit           clr;
    logic [W-1:0] exp_bits;   // bit n = value seen on the n-th valid cycle
    int           exp_done;
    int           exp_ready;
    int           exp_clr;
  } vec_t;

  typedef struct {
    logic [W-1:0] bits;
    int           done_j;
    int           ready_j;
    int           clr_n;
    int           done_n;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_pattern_serializer_if #(.WIDTH(W)) bus ();

  seq_pattern_serializer #(
    .WIDTH      (W),
    .CLR_CYCLES (CLR),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic obs_t observe();
    return {bus.pat_ready, bus.busy, bus.det_clr, bus.seq_valid,
            bus.seq_out, bus.frame_done, bus.bit_idx};
  endfunction

  // Expected outputs j cycles after the transfer edge, from the latency rules
  function automatic obs_t model(input int j, input logic [W-1:0] pat,
                                 input bit clr, input int reps);
    int   off, t, u;
    bit   dclr, shifting, done, ready;
    logic sbit;
    int   idx;
    off      = clr ? CLR : 0;
    t        = j - 1 - off;
    dclr     = clr && (j >= 1) && (j <= CLR);
    ready    = (t >= (reps + 1) * P);
    shifting = 1'b0;
    sbit     = 1'b0;
    idx      = 0;
    done     = 1'b0;
    if (t >= 0 && !ready) begin
      u = t % P;
      if (u < W) begin
        shifting = 1'b1;
        sbit     = pat[u];
        idx      = u;
      end
    end
    if (t >= W && ((t - W) % P) == 0 && ((t - W) / P) <= reps) done = 1'b1;
    return {ready, ~ready, dclr, shifting, sbit, done, IDX_W'(idx)};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (rdy,busy,clr,vld,out,done,idx)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_rep(input int r);
`ifdef SER_REPEAT_EN
    bus.rep_cnt = 4'(r);
`else
    if (r != 0) begin
      bad++;
      $display("FAIL set_rep: got %0d want 0", r);
    end
`endif
  endtask

  task automatic start(input logic [W-1:0] pat, input bit clr, input int reps);
    bus.pat_valid = 1'b1;
    bus.pat_data  = pat;
    bus.clr_req   = clr;
    set_rep(reps);
  endtask

  task automatic idle(input int n);
    bus.pat_valid = 1'b0;
    repeat (n) begin
      bus.pat_data = W'($urandom);
      bus.clr_req  = 1'($urandom);
      @(negedge clk);
      check("idle", observe(), RST_OBS);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, " async"}, observe(), RST_OBS);
    bus.pat_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " held"}, observe(), RST_OBS);
    reset = 1'b1;
  endtask

  // Called at a negedge with the transfer already presented; checks every
  // cycle up to the return of pat_ready (or aborts with reset at abort_j).
  task automatic run_frame(input logic [W-1:0] pat, input bit clr, input int reps,
                           input int abort_j, input bit chain,
                           input logic [W-1:0] npat, input bit nclr, input int nreps,
                           output res_t res);
    int last, nb;
    last        = (clr ? CLR : 0) + (reps + 1) * P + 1;
    nb          = 0;
    res.bits    = '0;
    res.done_j  = -1;
    res.ready_j = -1;
    res.clr_n   = 0;
    res.done_n  = 0;
    @(posedge clk);
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      if (j == 1) begin
        if (chain) begin
          start(npat, nclr, nreps);
        end else begin
          bus.pat_valid = 1'b0;
          bus.pat_data  = W'($urandom);
          bus.clr_req   = 1'($urandom);
        end
      end
      check($sformatf("frame %h clr=%0d j=%0d", pat, clr, j), observe(), model(j, pat, clr, reps));
      if (bus.seq_valid && nb < W) begin
        res.bits[nb] = bus.seq_out;
        nb++;
      end
      if (bus.frame_done) begin
        res.done_n++;
        if (res.done_j < 0) res.done_j = j;
      end
      if (bus.pat_ready && res.ready_j < 0) res.ready_j = j;
      if (bus.det_clr) res.clr_n++;
      if (j == abort_j) begin
        do_reset($sformatf("abort j=%0d", j));
        return;
      end
    end
  endtask

  vec_t         vecs[5];
  res_t         res;
  logic [W-1:0] p, np;
  bit           c, nc, chain;
  int           r, nr;

  initial begin
    vecs[0] = '{12'b0000_0001_0110, 1'b0, 12'b0000_0001_0110, 13, 14, 0};
    vecs[1] = '{12'b0000_0001_0110, 1'b1, 12'b0000_0001_0110, 15, 16, 2};
    vecs[2] = '{12'hFFF,            1'b0, 12'hFFF,            13, 14, 0};
    vecs[3] = '{12'h800,            1'b1, 12'h800,            15, 16, 2};
    vecs[4] = '{12'hA5C,            1'b0, 12'hA5C,            13, 14, 0};

    bus.pat_valid = 1'b0;
    bus.pat_data  = '0;
    bus.clr_req   = 1'b0;
    set_rep(0);
    #2 reset = 1'b0;
    #1 check("reset state", observe(), RST_OBS);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      start(vecs[i].pat, vecs[i].clr, 0);
      run_frame(vecs[i].pat, vecs[i].clr, 0, 0, 1'b0, '0, 1'b0, 0, res);
      check_int($sformatf("tbl%0d bits", i), int'(res.bits), int'(vecs[i].exp_bits));
      check_int($sformatf("tbl%0d done_cycle", i), res.done_j, vecs[i].exp_done);
      check_int($sformatf("tbl%0d ready_cycle", i), res.ready_j, vecs[i].exp_ready);
      check_int($sformatf("tbl%0d clr_cycles", i), res.clr_n, vecs[i].exp_clr);
      check_int($sformatf("tbl%0d done_pulses", i), res.done_n, 1);
      idle(1);
    end

    // Back-to-back: B held valid during A, taken in the first IDLE cycle
    start(12'h3C5, 1'b0, 0);
    run_frame(12'h3C5, 1'b0, 0, 0, 1'b1, 12'h9A6, 1'b1, 0, res);
    run_frame(12'h9A6, 1'b1, 0, 0, 1'b0, '0, 1'b0, 0, res);
    check_int("b2b second bits", int'(res.bits), int'(12'h9A6));
    idle(1);

    // Reset while bit 5 is on the line, then a clean frame
    start(12'h7E1, 1'b0, 0);
    run_frame(12'h7E1, 1'b0, 0, 6, 1'b0, '0, 1'b0, 0, res);
    check_int("abort no done", res.done_n, 0);
    idle(3);
    start(12'h0F3, 1'b0, 0);
    run_frame(12'h0F3, 1'b0, 0, 0, 1'b0, '0, 1'b0, 0, res);
    check_int("post-abort bits", int'(res.bits), int'(12'h0F3));

    // Reset while det_clr is high
    start(12'h555, 1'b1, 0);
    run_frame(12'h555, 1'b1, 0, 1, 1'b0, '0, 1'b0, 0, res);
    idle(2);

`ifdef SER_REPEAT_EN
    // Three repetitions with one leading clear
    start(12'hB2D, 1'b1, 2);
    run_frame(12'hB2D, 1'b1, 2, 0, 1'b0, '0, 1'b0, 0, res);
    check_int("rep done_pulses", res.done_n, 3);
    check_int("rep clr_cycles", res.clr_n, CLR);
    set_rep(0);
    idle(1);
`endif

    // Randomized frames, chained or separated by random idle time
    p = W'($urandom);
    c = 1'($urandom);
`ifdef SER_REPEAT_EN
    r = $urandom_range(0, 2);
`else
    r = 0;
`endif
    start(p, c, r);
    for (int it = 0; it < 30; it++) begin
      np    = W'($urandom);
      nc    = 1'($urandom);
      chain = 1'($urandom);
`ifdef SER_REPEAT_EN
      nr = $urandom_range(0, 2);
`else
      nr = 0;
`endif
      run_frame(p, c, r, 0, chain, np, nc, nr, res);
      if (!chain) begin
        idle($urandom_range(0, 3));
        start(np, nc, nr);
      end
      p = np;
      c = nc;
      r = nr;
    end
    run_frame(p, c, r, 0, 1'b0, '0, 1'b0, 0, res);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_pattern_serializer.md
Name: seq_pattern_serializer

Overview:
Upstream stimulus stage for the sequence detectors. Accepts a WIDTH-bit pattern through a valid/ready handshake. Optionally pulses a detector clear, then presents the pattern one bit per clock on seq_out, starting with the right-most bit (LSB first). Raises frame_done when the detector's final-bit response is observable, so the result can be sampled without a free-running bench loop.

Parameters:
WIDTH, 12, pattern length in bits (>=2)
CLR_CYCLES, 2, cycles det_clr is held high before the first bit (>=1)
GAP_CYCLES, 1, idle cycles after the last bit before pat_ready returns (>=0)

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-low; low forces all state to reset values immediately
pat_data  in  WIDTH  pattern to serialize; bit 0 is sent first
pat_valid  in  1  pat_data/clr_req are valid
pat_ready  out  1  high only in IDLE; transfer occurs on a posedge with pat_valid&pat_ready
clr_req  in  1  sampled with pat_data; 1 = issue det_clr before shifting
det_clr  out  1  active-high clear for the downstream detector
seq_out  out  1  serial bit to the detector; registered, stable for a full cycle
seq_valid  out  1  high while seq_out carries a pattern bit
busy  out  1  high in any state other than IDLE
frame_done  out  1  single-cycle pulse, cycle after the last bit
bit_idx  out  clog2(WIDTH)  index of the bit currently on seq_out; 0 outside SHIFT

Behaviour:
- Reset values: state=IDLE, pat_ready=1, det_clr=0, seq_out=0, seq_valid=0, busy=0, frame_done=0, bit_idx=0, shift register=0.
- FSM states (2-bit): IDLE=0, CLEAR=1, SHIFT=2, GAP=3.
- IDLE:
  - On a transfer, capture pat_data into the shift register and capture clr_req.
  - Next state is CLEAR if clr_req=1, otherwise SHIFT.
  - While pat_valid=0, or while not in IDLE, nothing is captured. pat_data changes outside IDLE are ignored.
- CLEAR:
  - det_clr=1 for exactly CLR_CYCLES cycles; seq_valid=0, seq_out=0.
  - Then go to SHIFT.
- SHIFT:
  - seq_out = shreg[0], seq_valid=1, bit_idx counts 0..WIDTH-1.
  - The register shifts right once per cycle.
  - After WIDTH cycles go to GAP, or to IDLE if GAP_CYCLES=0.
- frame_done: asserted for one cycle, in the first cycle after the last SHIFT cycle. seq_out=0 and seq_valid=0 in that cycle.
- GAP: lasts GAP_CYCLES cycles with all outputs idle, then IDLE.
- Latency, for a transfer at edge k with no clear:
  - bit i is on seq_out during cycle k+1+i;
  - frame_done in cycle k+1+WIDTH;
  - pat_ready high again in cycle k+1+WIDTH+GAP_CYCLES.
- A clear adds CLR_CYCLES to every figure above.
- Back-to-back patterns: pat_valid held high is accepted in the first IDLE cycle, so there is no lost cycle beyond GAP.
- Counter: one down-counter is reloaded on each state entry with CLR_CYCLES-1, WIDTH-1 or GAP_CYCLES-1. The state exits when the count reaches 0. No wrap-around is possible.
- Reset mid-operation: the frame is aborted with no frame_done and det_clr drops at once. After release, state is IDLE and pat_ready=1.

Optional Feature:
SER_REPEAT_EN
- Defined:
  - Adds input rep_cnt[3:0], sampled at transfer; the pattern is sent rep_cnt+1 times.
  - Each repetition is separated by a GAP; det_clr is issued only before the first repetition.
  - frame_done pulses after every repetition; busy stays high until the final GAP ends.
  - A copy of the pattern is held so it can be reloaded for each repetition.
- Undefined: no rep_cnt port and single transmission; logic is identical to the feature with rep_cnt=0.

Decomposition:
- Package seq_ser_pkg:
  - state encodings IDLE/CLEAR/SHIFT/GAP;
  - default WIDTH, CLR_CYCLES and GAP_CYCLES;
  - a clog2 constant function for the counter and bit_idx widths.
- Sub-module seq_ser_cnt: loadable down-counter with load value, load strobe, decrement enable and zero flag. Used for the CLEAR, SHIFT and GAP durations.

Test Plan:
- Reset check: drive reset low mid-sim -> all outputs at reset values within the same cycle; pat_ready=1 after release.
- Serial order: pat_data=12'b0000_0001_0110, clr_req=0, transfer at edge k -> seq_out in cycles k+1..k+12 = 0,1,1,0,1,0,0,0,0,0,0,0; frame_done only in k+13; pat_ready=1 in k+14.
- Clear path: clr_req=1, same pattern -> det_clr=1 in k+1,k+2 only; first bit in k+3; frame_done in k+15.
- Handshake: pat_valid held high with data A then B -> B captured only in the first IDLE cycle after A; pat_ready=0 throughout A; no bits dropped.
- Reset mid-shift: reset low while bit_idx=5 -> seq_valid=0 and det_clr=0 immediately; no frame_done; the next transfer starts a clean frame with bit 0.
- SER_REPEAT_EN with rep_cnt=2 and clr_req=1 -> three identical 12-bit frames, det_clr asserted only once, three frame_done pulses, busy low only after the third GAP.
